// File: rtl/sw_input_conditioner.sv
// sw_input_conditioner: board input front end for the RISC-V core.
// Synchronises and debounces the run button and switch vector, turns debounced
// run presses into a one-cycle strobe, and hands a switch snapshot per press to
// the core over a valid/ready handshake with a sticky overrun flag.
module sw_input_conditioner #(
    parameter int SW_WIDTH        = 8,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic                run_raw,
    input  logic [SW_WIDTH-1:0] sw_raw,
    input  logic                sw_ready,
    input  logic                overrun_clr,
    output logic                run_level,
    output logic                run_pulse,
    output logic [SW_WIDTH-1:0] sw_stable,
    output logic [SW_WIDTH-1:0] sw_data,
    output logic                sw_valid,
    output logic                overrun
);

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HOLD     = 2'd1,
        WAIT_REL = 2'd2
    } state_t;

    logic                run_meta, run_sync;
    logic [SW_WIDTH-1:0] sw_meta, sw_sync, sw_prev;
    logic [CNT_WIDTH-1:0] run_cnt, sw_cnt;
    logic                run_level_q;
    state_t              state;

    // Two-flop synchronisers; the switch vector is synchronised bit by bit.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            run_meta <= 1'b0;
            run_sync <= 1'b0;
            sw_meta  <= '0;
            sw_sync  <= '0;
        end else begin
            run_meta <= run_raw;
            run_sync <= run_meta;
            sw_meta  <= sw_raw;
            sw_sync  <= sw_meta;
        end
    end

    // Run debounce: count cycles the synced level disagrees with run_level.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            run_cnt   <= '0;
            run_level <= 1'b0;
        end else if (run_sync != run_level) begin
            if (run_cnt == CNT_LAST) begin
                run_level <= run_sync;
                run_cnt   <= '0;
            end else begin
                run_cnt <= run_cnt + CNT_ONE;
            end
        end else begin
            run_cnt <= '0;
        end
    end

    // Switch debounce: one shared counter. The counter holds the number of
    // cycles the synced vector has held its current value, so the cycle on
    // which a new value first appears already counts as one; any bit change
    // restarts the count, which keeps a clean edge at the same latency as run.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sw_prev   <= '0;
            sw_cnt    <= '0;
            sw_stable <= '0;
        end else begin
            sw_prev <= sw_sync;
            if (sw_sync != sw_prev) begin
                sw_cnt <= (sw_sync != sw_stable) ? CNT_ONE : '0;
            end else if (sw_sync != sw_stable) begin
                if (sw_cnt == CNT_LAST) begin
                    sw_stable <= sw_sync;
                    sw_cnt    <= '0;
                end else begin
                    sw_cnt <= sw_cnt + CNT_ONE;
                end
            end else begin
                sw_cnt <= '0;
            end
        end
    end

    // Press strobe: registered rising-edge detect, one cycle after run_level rises.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            run_level_q <= 1'b0;
            run_pulse   <= 1'b0;
        end else begin
            run_level_q <= run_level;
            run_pulse   <= run_level & ~run_level_q;
        end
    end

    // Capture FSM: snapshot on a press, hold until the core takes it, then
    // wait for the button to be released. A press while holding only flags overrun.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state    <= IDLE;
            sw_data  <= '0;
            sw_valid <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            // Set has priority over clear so a coincident press is never lost.
            if (run_pulse && state == HOLD) overrun <= 1'b1;
            else if (overrun_clr)           overrun <= 1'b0;

            case (state)
                IDLE: begin
                    if (run_pulse) begin
                        sw_data  <= sw_stable;
                        sw_valid <= 1'b1;
                        state    <= HOLD;
                    end
                end
                HOLD: begin
                    if (sw_ready) begin
                        sw_valid <= 1'b0;
                        state    <= run_level ? WAIT_REL : IDLE;
                    end
                end
                WAIT_REL: begin
                    if (!run_level) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
